// File: rtl/decode_issue_if.sv
// Fetch-to-decode request and decode-to-execute issue bundle.
// The master modport is the decode/issue stage; slave is its environment.
interface decode_issue_if;
    logic [15:0] instr;
    logic [15:0] pc_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        ex_ready;
    logic        flush;
    logic        id_valid;
    logic [4:0]  Alu_op;
    logic [1:0]  Op_ext;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [15:0] imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] epc;
    logic        halted;

    modport master (
        input  instr, pc_in, instr_valid, ex_ready, flush,
        output instr_ready, id_valid, Alu_op, Op_ext, rs, rt, rd, imm,
               reg_write, mem_read, mem_write, redirect, redirect_pc, epc, halted
    );

    modport slave (
        output instr, pc_in, instr_valid, ex_ready, flush,
        input  instr_ready, id_valid, Alu_op, Op_ext, rs, rt, rd, imm,
               reg_write, mem_read, mem_write, redirect, redirect_pc, epc, halted
    );
endinterface

// File: rtl/decode_issue.sv
// Decode and issue stage: registers the decoded bundle for execute and owns
// the RUN/HALT/EXC machine state, exception PC and fetch redirect.
module decode_issue #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] SIIC_VEC = 16'h0002
) (
    input  logic          clk,
    input  logic          rst_n,
    decode_issue_if.master bus
);

    typedef enum logic [1:0] {S_RUN, S_HALT, S_EXC} state_e;

    typedef struct packed {
        logic [4:0]  alu_op;
        logic [1:0]  op_ext;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  rd;
        logic [15:0] imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } bundle_t;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;
    localparam logic [4:0] OP_SIIC = 5'b00010;
    localparam logic [4:0] OP_RTI  = 5'b00011;

    localparam bundle_t BUNDLE_RST = '{alu_op: OP_NOP, op_ext: 2'b00, rs: 3'd0, rt: 3'd0,
                                       rd: 3'd0, imm: 16'h0000, reg_write: 1'b0,
                                       mem_read: 1'b0, mem_write: 1'b0};

    state_e      state_q, state_d;
    bundle_t     bundle_q, dec;
    logic        id_valid_q, id_valid_d;
    logic        redirect_q, redirect_d;
    logic [15:0] redirect_pc_q, redirect_pc_d;
    logic [15:0] epc_q, epc_d;
    logic [4:0]  op;
    logic        instr_ready;
    logic        accept;

    assign op     = bus.instr[15:11];
    assign accept = bus.instr_valid & instr_ready;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        dec           = '0;
        dec.alu_op    = op;
        dec.op_ext    = bus.instr[1:0];
        dec.rs        = bus.instr[10:8];
        dec.rt        = bus.instr[7:5];
        casez (op)
            5'b11011, 5'b111??: begin
                dec.rd        = bus.instr[4:2];
                dec.reg_write = 1'b1;
            end
            5'b010??: begin
                dec.rd        = bus.instr[7:5];
                dec.reg_write = 1'b1;
                // ADDI/SUBI sign-extend; XORI/ANDNI are logical and zero-extend.
                dec.imm       = op[1] ? {11'd0, bus.instr[4:0]}
                                      : {{11{bus.instr[4]}}, bus.instr[4:0]};
            end
            5'b101??: begin
                dec.rd        = bus.instr[7:5];
                dec.reg_write = 1'b1;
                dec.imm       = {11'd0, bus.instr[4:0]};
            end
            5'b10001: begin
                dec.rd        = bus.instr[7:5];
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                dec.imm       = {{11{bus.instr[4]}}, bus.instr[4:0]};
            end
            5'b10011: begin
                dec.rd        = bus.instr[7:5];
                dec.reg_write = 1'b1;
                dec.mem_write = 1'b1;
                dec.imm       = {{11{bus.instr[4]}}, bus.instr[4:0]};
            end
            5'b10000: begin
                dec.mem_write = 1'b1;
                dec.imm       = {{11{bus.instr[4]}}, bus.instr[4:0]};
            end
            5'b10010: begin
                dec.rd        = bus.instr[10:8];
                dec.reg_write = 1'b1;
                dec.imm       = {8'd0, bus.instr[7:0]};
            end
            5'b11000: begin
                dec.rd        = bus.instr[10:8];
                dec.reg_write = 1'b1;
                dec.imm       = {{8{bus.instr[7]}}, bus.instr[7:0]};
            end
            5'b11001: begin
                dec.rd        = bus.instr[10:8];
                dec.reg_write = 1'b1;
            end
            5'b011??, 5'b00101: dec.imm = {{8{bus.instr[7]}}, bus.instr[7:0]};
            5'b00100:           dec.imm = {{5{bus.instr[10]}}, bus.instr[10:0]};
            5'b00110: begin
                dec.rd        = 3'd7;
                dec.reg_write = 1'b1;
                dec.imm       = {{5{bus.instr[10]}}, bus.instr[10:0]};
            end
            5'b00111: begin
                dec.rd        = 3'd7;
                dec.reg_write = 1'b1;
                dec.imm       = {{8{bus.instr[7]}}, bus.instr[7:0]};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        id_valid_d    = id_valid_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        epc_d         = epc_q;
        instr_ready   = (state_q == S_RUN) & (~id_valid_q | bus.ex_ready) & ~bus.flush;

        if (bus.flush)                       id_valid_d = 1'b0;
        else if (accept)                     id_valid_d = 1'b1;
        else if (id_valid_q && bus.ex_ready) id_valid_d = 1'b0;

        unique case (state_q)
            S_RUN: begin
                if (accept) begin
                    unique case (op)
                        OP_HALT: state_d = S_HALT;
                        OP_SIIC: begin
                            state_d       = S_EXC;
                            epc_d         = bus.pc_in + 16'd2;
                            redirect_d    = 1'b1;
                            redirect_pc_d = SIIC_VEC;
                        end
                        OP_RTI: begin
                            redirect_d    = 1'b1;
                            redirect_pc_d = epc_q;
                        end
                        default: ;
                    endcase
                end
            end
            S_EXC:   state_d = S_RUN;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RUN;
            bundle_q      <= BUNDLE_RST;
            id_valid_q    <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 16'h0000;
            epc_q         <= RESET_PC;
        end else begin
            state_q       <= state_d;
            id_valid_q    <= id_valid_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            epc_q         <= epc_d;
            if (accept) bundle_q <= dec;
        end
    end

    assign bus.instr_ready = instr_ready;
    assign bus.id_valid    = id_valid_q;
    assign bus.Alu_op      = bundle_q.alu_op;
    assign bus.Op_ext      = bundle_q.op_ext;
    assign bus.rs          = bundle_q.rs;
    assign bus.rt          = bundle_q.rt;
    assign bus.rd          = bundle_q.rd;
    assign bus.imm         = bundle_q.imm;
    assign bus.reg_write   = bundle_q.reg_write;
    assign bus.mem_read    = bundle_q.mem_read;
    assign bus.mem_write   = bundle_q.mem_write;
    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.epc         = epc_q;
    assign bus.halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: decode table plus stall, exception,
// flush, halt and asynchronous-reset sequences.
module tb_decode_issue;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    decode_issue_if bus ();

    decode_issue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [34:0] exp;
    } vec_t;

    vec_t vecs [17];

    function automatic logic [34:0] pack(input logic [4:0] alu, input logic [1:0] ext,
                                         input logic [2:0] rs, input logic [2:0] rt,
                                         input logic [2:0] rd, input logic [15:0] imm,
                                         input logic rw, input logic mr, input logic mw);
        return {alu, ext, rs, rt, rd, imm, rw, mr, mw};
    endfunction

    function automatic logic [34:0] bundle();
        return {bus.Alu_op, bus.Op_ext, bus.rs, bus.rt, bus.rd, bus.imm,
                bus.reg_write, bus.mem_read, bus.mem_write};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{16'hD94C, pack(5'b11011, 2'b00, 3'd1, 3'd2, 3'd3, 16'h0000, 1'b1, 1'b0, 1'b0)};
        vecs[1]  = '{16'h485F, pack(5'b01001, 2'b11, 3'd0, 3'd2, 3'd2, 16'hFFFF, 1'b1, 1'b0, 1'b0)};
        vecs[2]  = '{16'h505F, pack(5'b01010, 2'b11, 3'd0, 3'd2, 3'd2, 16'h001F, 1'b1, 1'b0, 1'b0)};
        vecs[3]  = '{16'h8B90, pack(5'b10001, 2'b00, 3'd3, 3'd4, 3'd4, 16'hFFF0, 1'b1, 1'b1, 1'b0)};
        vecs[4]  = '{16'h8385, pack(5'b10000, 2'b01, 3'd3, 3'd4, 3'd0, 16'h0005, 1'b0, 1'b0, 1'b1)};
        vecs[5]  = '{16'h9D3E, pack(5'b10011, 2'b10, 3'd5, 3'd1, 3'd1, 16'hFFFE, 1'b1, 1'b0, 1'b1)};
        vecs[6]  = '{16'hC680, pack(5'b11000, 2'b00, 3'd6, 3'd4, 3'd6, 16'hFF80, 1'b1, 1'b0, 1'b0)};
        vecs[7]  = '{16'h9281, pack(5'b10010, 2'b01, 3'd2, 3'd4, 3'd2, 16'h0081, 1'b1, 1'b0, 1'b0)};
        vecs[8]  = '{16'h2400, pack(5'b00100, 2'b00, 3'd4, 3'd0, 3'd0, 16'hFC00, 1'b0, 1'b0, 1'b0)};
        vecs[9]  = '{16'h3005, pack(5'b00110, 2'b01, 3'd0, 3'd0, 3'd7, 16'h0005, 1'b1, 1'b0, 1'b0)};
        vecs[10] = '{16'h39FF, pack(5'b00111, 2'b11, 3'd1, 3'd7, 3'd7, 16'hFFFF, 1'b1, 1'b0, 1'b0)};
        vecs[11] = '{16'h6203, pack(5'b01100, 2'b11, 3'd2, 3'd0, 3'd0, 16'h0003, 1'b0, 1'b0, 1'b0)};
        vecs[12] = '{16'hA155, pack(5'b10100, 2'b01, 3'd1, 3'd2, 3'd2, 16'h0015, 1'b1, 1'b0, 1'b0)};
        vecs[13] = '{16'h0800, pack(5'b00001, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0)};
        vecs[14] = '{16'hCB80, pack(5'b11001, 2'b00, 3'd3, 3'd4, 3'd3, 16'h0000, 1'b1, 1'b0, 1'b0)};
        vecs[15] = '{16'hE5DE, pack(5'b11100, 2'b10, 3'd5, 3'd6, 3'd7, 16'h0000, 1'b1, 1'b0, 1'b0)};
        vecs[16] = '{16'h5970, pack(5'b01011, 2'b00, 3'd1, 3'd3, 3'd3, 16'h0010, 1'b1, 1'b0, 1'b0)};

        rst_n           = 1'b0;
        bus.instr       = 16'h0000;
        bus.pc_in       = 16'h0000;
        bus.instr_valid = 1'b0;
        bus.ex_ready    = 1'b1;
        bus.flush       = 1'b0;
        repeat (2) tick();

        check("rst id_valid", 64'(bus.id_valid), 64'(0));
        check("rst bundle", 64'(bundle()),
              64'(pack(5'b00001, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0)));
        check("rst redirect", 64'(bus.redirect), 64'(0));
        check("rst redirect_pc", 64'(bus.redirect_pc), 64'(0));
        check("rst epc", 64'(bus.epc), 64'(0));
        check("rst halted", 64'(bus.halted), 64'(0));
        check("rst instr_ready", 64'(bus.instr_ready), 64'(1));
        rst_n = 1'b1;

        // Back-to-back decode table with execute always ready.
        for (int i = 0; i < 17; i++) begin
            bus.instr       = vecs[i].instr;
            bus.pc_in       = 16'(i * 2);
            bus.instr_valid = 1'b1;
            tick();
            check($sformatf("vec%0d id_valid", i), 64'(bus.id_valid), 64'(1));
            check($sformatf("vec%0d bundle", i), 64'(bundle()), 64'(vecs[i].exp));
        end
        bus.instr_valid = 1'b0;
        tick();
        check("drain id_valid", 64'(bus.id_valid), 64'(0));

        // Stall: ADD held for three cycles while SUBI waits, then SUBI/XORI stream.
        bus.instr       = 16'hD94C;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr    = 16'h485F;
        bus.ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall%0d instr_ready", i), 64'(bus.instr_ready), 64'(0));
            tick();
            check($sformatf("stall%0d alu_op", i), 64'(bus.Alu_op), 64'(5'b11011));
            check($sformatf("stall%0d id_valid", i), 64'(bus.id_valid), 64'(1));
        end
        bus.ex_ready = 1'b1;
        #1;
        check("resume instr_ready", 64'(bus.instr_ready), 64'(1));
        tick();
        check("resume subi", 64'(bundle()), 64'(vecs[1].exp));
        bus.instr = 16'h505F;
        tick();
        check("resume xori", 64'(bundle()), 64'(vecs[2].exp));
        check("resume xori valid", 64'(bus.id_valid), 64'(1));
        bus.instr_valid = 1'b0;
        tick();
        check("resume drain", 64'(bus.id_valid), 64'(0));

        // SIIC at the top of the address space: epc wraps.
        bus.instr       = 16'h1000;
        bus.pc_in       = 16'hFFFE;
        bus.instr_valid = 1'b1;
        tick();
        check("siic wrap epc", 64'(bus.epc), 64'(16'h0000));
        check("siic wrap redirect", 64'(bus.redirect), 64'(1));
        check("siic wrap instr_ready", 64'(bus.instr_ready), 64'(0));
        bus.instr_valid = 1'b0;
        tick();
        check("siic wrap redirect end", 64'(bus.redirect), 64'(0));
        check("siic wrap back to run", 64'(bus.instr_ready), 64'(1));

        // SIIC at 0x0040, NOP offered during EXC, then RTI returns to epc.
        bus.instr       = 16'h1000;
        bus.pc_in       = 16'h0040;
        bus.instr_valid = 1'b1;
        tick();
        check("siic epc", 64'(bus.epc), 64'(16'h0042));
        check("siic redirect", 64'(bus.redirect), 64'(1));
        check("siic redirect_pc", 64'(bus.redirect_pc), 64'(16'h0002));
        check("siic issued", 64'({bus.id_valid, bus.Alu_op}), 64'({1'b1, 5'b00010}));
        bus.instr = 16'h0800;
        bus.pc_in = 16'h0042;
        #1;
        check("exc instr_ready", 64'(bus.instr_ready), 64'(0));
        tick();
        check("exc nothing accepted", 64'({bus.id_valid, bus.Alu_op}), 64'({1'b0, 5'b00010}));
        check("exc redirect end", 64'(bus.redirect), 64'(0));
        tick();
        check("nop issued", 64'({bus.id_valid, bundle()}), 64'({1'b1, vecs[13].exp}));
        bus.instr = 16'h1800;
        bus.pc_in = 16'h0050;
        tick();
        check("rti redirect", 64'(bus.redirect), 64'(1));
        check("rti redirect_pc", 64'(bus.redirect_pc), 64'(16'h0042));
        check("rti epc", 64'(bus.epc), 64'(16'h0042));
        check("rti alu_op", 64'(bus.Alu_op), 64'(5'b00011));
        bus.instr_valid = 1'b0;
        tick();
        check("rti redirect end", 64'(bus.redirect), 64'(0));

        // Flush with a JAL held and a new instruction offered.
        bus.instr       = 16'h3005;
        bus.instr_valid = 1'b1;
        tick();
        check("jal held", 64'({bus.id_valid, bus.Alu_op}), 64'({1'b1, 5'b00110}));
        bus.ex_ready = 1'b0;
        bus.instr    = 16'hD94C;
        bus.flush    = 1'b1;
        #1;
        check("flush instr_ready", 64'(bus.instr_ready), 64'(0));
        tick();
        check("flush killed", 64'({bus.id_valid, bus.Alu_op}), 64'({1'b0, 5'b00110}));
        check("flush epc", 64'(bus.epc), 64'(16'h0042));
        bus.flush = 1'b0;
        tick();
        check("after flush add", 64'({bus.id_valid, bus.Alu_op}), 64'({1'b1, 5'b11011}));
        bus.ex_ready    = 1'b1;
        bus.instr_valid = 1'b0;
        tick();

        // HALT drains downstream, then the stage stays stopped.
        bus.instr       = 16'h0000;
        bus.instr_valid = 1'b1;
        tick();
        check("halt issued", 64'({bus.id_valid, bus.Alu_op}), 64'({1'b1, 5'b00000}));
        check("halt halted", 64'(bus.halted), 64'(1));
        check("halt instr_ready", 64'(bus.instr_ready), 64'(0));
        bus.instr    = 16'hD94C;
        bus.ex_ready = 1'b0;
        tick();
        check("halt held", 64'({bus.id_valid, bus.Alu_op}), 64'({1'b1, 5'b00000}));
        bus.ex_ready = 1'b1;
        tick();
        check("halt drained", 64'({bus.id_valid, bus.Alu_op}), 64'({1'b0, 5'b00000}));
        repeat (3) tick();
        check("halt sticky", 64'({bus.halted, bus.instr_ready, bus.id_valid}), 64'(3'b100));

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("async halted", 64'(bus.halted), 64'(0));
        check("async bundle", 64'({bus.id_valid, bundle()}),
              64'({1'b0, pack(5'b00001, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0)}));
        check("async epc", 64'(bus.epc), 64'(16'h0000));
        check("async redirect", 64'({bus.redirect, bus.redirect_pc}), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
